// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 codes, FSM encoding
// and the latency counter width.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmemState_t;
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores: byte enables, replicated write data,
// sign/zero-extended load data and the misalign/illegal-size error flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataSh,
    output logic [31:0] rdataExt,
    output logic        err
);
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign selByte = rword[addrLo*8 +: 8];
    assign selHalf = addrLo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        err      = 1'b0;
        byteEn   = 4'b0000;
        wdataSh  = 32'h0;
        rdataExt = 32'h0;
        case (funct3)
            F3_B, F3_BU: begin
                // Unsigned variants only exist for loads.
                err      = we && (funct3 == F3_BU);
                byteEn   = 4'b0001 << addrLo;
                wdataSh  = {4{wdata[7:0]}};
                rdataExt = (funct3 == F3_B) ? {{24{selByte[7]}}, selByte}
                                            : {24'h0, selByte};
            end
            F3_H, F3_HU: begin
                err      = addrLo[0] || (we && (funct3 == F3_HU));
                byteEn   = addrLo[1] ? 4'b1100 : 4'b0011;
                wdataSh  = {2{wdata[15:0]}};
                rdataExt = (funct3 == F3_H) ? {{16{selHalf[15]}}, selHalf}
                                            : {16'h0, selHalf};
            end
            F3_W: begin
                err      = (addrLo != 2'b00);
                byteEn   = 4'b1111;
                wdataSh  = wdata;
                rdataExt = rword;
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            byteEn   = 4'b0000;
            rdataExt = 32'h0;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request, programmable
// wait before the array access, response held until the core takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    dmemState_t       state;
    logic [CNT_W-1:0] cnt;
    logic             weQ;
    logic [AW+1:0]    addrQ;
    logic [31:0]      wdataQ;
    logic [2:0]       funct3Q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rword;
    logic [3:0]  byteEn;
    logic [31:0] wdataSh;
    logic [31:0] rdataExt;
    logic        alignErr;
    logic        doAccess;

    assign rword    = mem[addrQ[AW+1:2]];
    assign doAccess = (state == ST_WAIT) && (cnt == '0);

    dmem_lane_align uAlign (
        .we       (weQ),
        .funct3   (funct3Q),
        .addrLo   (addrQ[1:0]),
        .wdata    (wdataQ),
        .rword    (rword),
        .byteEn   (byteEn),
        .wdataSh  (wdataSh),
        .rdataExt (rdataExt),
        .err      (alignErr)
    );

    // Array has no reset; a reset on the access edge still suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && doAccess && weQ) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[addrQ[AW+1:2]][i*8 +: 8] <= wdataSh[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            weQ       <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= 32'h0;
            funct3Q   <= 3'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        weQ       <= req_we;
                        addrQ     <= req_addr[AW+1:0];
                        wdataQ    <= req_wdata;
                        funct3Q   <= req_funct3;
                        cnt       <= CNT_W'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_rdata <= weQ ? 32'h0 : rdataExt;
                        rsp_err   <= alignErr;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder: table of load/store transactions
// plus hand-written back-pressure and reset-abort sequences.
module tb_dmem_responder;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_funct3 = 3'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endtask

    task automatic addVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] expRd, input logic expErr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.expRd = expRd; v.expErr = expErr;
        vecs.push_back(v);
    endtask

    // Full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rd, output logic e,
                        output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        rd = rsp_rdata;
        e  = rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd, hold;
        logic        e;
        int          lat;

        addVec(1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        0);
        addVec(0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 0);
        addVec(0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 0);
        addVec(0, 32'h12,   32'h0,        3'b101, 32'h0000DEAD, 0);
        addVec(0, 32'h10,   32'h0,        3'b000, 32'hFFFFFFEF, 0);
        addVec(1, 32'h20,   32'h80FF7F01, 3'b010, 32'h0,        0);
        addVec(0, 32'h21,   32'h0,        3'b000, 32'h0000007F, 0);
        addVec(0, 32'h22,   32'h0,        3'b000, 32'hFFFFFFFF, 0);
        addVec(0, 32'h23,   32'h0,        3'b100, 32'h00000080, 0);
        addVec(0, 32'h22,   32'h0,        3'b001, 32'hFFFF80FF, 0);
        addVec(0, 32'h20,   32'h0,        3'b101, 32'h00007F01, 0);
        addVec(1, 32'h30,   32'h11223344, 3'b010, 32'h0,        0);
        addVec(1, 32'h31,   32'h000000AA, 3'b000, 32'h0,        0);
        addVec(1, 32'h32,   32'h0000BEEF, 3'b001, 32'h0,        0);
        addVec(0, 32'h30,   32'h0,        3'b010, 32'hBEEFAA44, 0);
        addVec(1, 32'h40,   32'hCAFEF00D, 3'b010, 32'h0,        0);
        addVec(0, 32'h42,   32'h0,        3'b010, 32'h0,        1);
        addVec(1, 32'h41,   32'h00001234, 3'b001, 32'h0,        1);
        addVec(0, 32'h40,   32'h0,        3'b010, 32'hCAFEF00D, 0);
        addVec(0, 32'h40,   32'h0,        3'b011, 32'h0,        1);
        addVec(0, 32'h41,   32'h0,        3'b101, 32'h0,        1);
        addVec(1, 32'h40,   32'h000000EE, 3'b100, 32'h0,        1);
        addVec(1, 32'h40,   32'hFFFFFFFF, 3'b110, 32'h0,        1);
        addVec(0, 32'h40,   32'h0,        3'b010, 32'hCAFEF00D, 0);
        addVec(1, 32'h1000, 32'hA5A5A5A5, 3'b010, 32'h0,        0);
        addVec(0, 32'h0,    32'h0,        3'b010, 32'hA5A5A5A5, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset rsp_err",   {31'h0, rsp_err}, 32'h0);

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, e, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
            chk($sformatf("vec%0d err", i), {31'h0, e}, {31'h0, vecs[i].expErr});
            chk($sformatf("vec%0d latency", i), lat, LAT + 1);
        end

        // Back-pressure: response held, a competing request must not be taken.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_funct3 = 3'b010;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 32'h10;
        chk("bp req_ready in WAIT", {31'h0, req_ready}, 32'h0);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 40);
        chk("bp rsp_valid seen", {31'h0, rsp_valid}, 32'h1);
        hold = rsp_rdata;
        chk("bp rdata", hold, 32'h80FF7F01);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d rdata stable", k), rsp_rdata, 32'h80FF7F01);
            chk($sformatf("bp%0d rsp_valid", k), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp%0d req_ready", k), {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release req_ready", {31'h0, req_ready}, 32'h1);
        chk("bp release rsp_valid", {31'h0, rsp_valid}, 32'h0);
        req_valid = 1'b0;

        // Reset while a store sits in WAIT: no write, outputs back to reset values.
        xact(1, 32'h50, 32'h0BADF00D, 3'b010, rd, e, lat);
        xact(0, 32'h50, 32'h0, 3'b010, rd, e, lat);
        chk("pre-abort load", rd, 32'h0BADF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hFFFFFFFF;
        req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort rsp_rdata", rsp_rdata, 32'h0);
        chk("abort rsp_err",   {31'h0, rsp_err}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort no response", {31'h0, rsp_valid}, 32'h0);
        xact(0, 32'h50, 32'h0, 3'b010, rd, e, lat);
        chk("abort no write", rd, 32'h0BADF00D);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
